// File: rtl/nn_pkg.sv
// Shared constants and types for the forward-propagation run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nn_pkg;
  localparam int DATA_W = 16;
  localparam int N_OUT  = 10;

  // Digit reported when the sequencer never signalled done.
  localparam logic [3:0] ERR_DIGIT = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SCAN,
    RELEASE,
    HOLD
  } classify_state_t;
endpackage

// File: rtl/argmax_acc.sv
// Running signed maximum and its index over a serial stream of values.
// Latency: result registered one cycle after the En cycle.
// Backpressure: none; every En cycle is consumed.
// Ports: Clk/Reset (sync, active-high); Clear restarts the search;
//        En/Idx/Val present one candidate; MaxIdx/MaxVal hold the best so far.
module argmax_acc #(
  parameter int DATA_W = nn_pkg::DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              En,
  input  logic [3:0]        Idx,
  input  logic [DATA_W-1:0] Val,
  output logic [3:0]        MaxIdx,
  output logic [DATA_W-1:0] MaxVal
);
  // Set after the first candidate so that it loads unconditionally.
  logic loaded;

  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      loaded <= 1'b0;
      MaxIdx <= '0;
      MaxVal <= '0;
    end else if (En && (!loaded || ($signed(Val) > $signed(MaxVal)))) begin
      // Strictly greater only: ties keep the earlier (lower) index.
      loaded <= 1'b1;
      MaxIdx <= Idx;
      MaxVal <= Val;
    end
  end
endmodule

// File: rtl/classify_ctrl.sv
// Host run controller: holds Compute until R, scans N_OUT outputs for argmax, reports digit/score.
// Latency: Valid N_OUT+4 cycles after R sampled high (plus R fall delay); timeout after TIMEOUT+3 cycles.
// Backpressure: result held in HOLD until Ack; Start ignored outside IDLE (not queued).
// Ports: Clk/Reset (sync, active-high); Start/Ack host handshake; R sequencer done;
//        OutVal/OutSel serial read of output neurons; Compute sequencer level;
//        Busy/Valid/Digit/Score/Err result to host.
module classify_ctrl #(
  parameter int DATA_W  = nn_pkg::DATA_W,
  parameter int N_OUT   = nn_pkg::N_OUT,
  parameter int TIMEOUT = 2047
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Ack,
  input  logic              R,
  input  logic [DATA_W-1:0] OutVal,
  output logic              Compute,
  output logic [3:0]        OutSel,
  output logic              Busy,
  output logic              Valid,
  output logic [3:0]        Digit,
  output logic [DATA_W-1:0] Score,
  output logic              Err
);
  import nn_pkg::*;

  localparam logic [10:0] TO_LIM    = 11'(TIMEOUT);
  localparam logic [3:0]  SCAN_LAST = 4'(N_OUT);

  classify_state_t state, state_nxt;

  logic [10:0]       to_cnt;
  logic [3:0]        scan_cnt;
  logic              err_q;
  logic              timed_out;
  logic              acc_clr;
  logic              acc_en;
  logic [3:0]        acc_idx;
  logic [3:0]        max_idx;
  logic [DATA_W-1:0] max_val;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      to_cnt   <= '0;
      scan_cnt <= '0;
      err_q    <= 1'b0;
      Digit    <= '0;
      Score    <= '0;
    end else begin
      state <= state_nxt;

      // Saturating wait counter; only runs while requesting.
      if (state == REQ) begin
        if (to_cnt != '1) to_cnt <= to_cnt + 11'd1;
      end else begin
        to_cnt <= '0;
      end

      if (state == SCAN) scan_cnt <= scan_cnt + 4'd1;
      else               scan_cnt <= '0;

      if (timed_out)          err_q <= 1'b1;
      else if (state == IDLE) err_q <= 1'b0;

      // Result registers move only when the result is published or retired.
      if (state == RELEASE && state_nxt == HOLD) begin
        Digit <= err_q ? ERR_DIGIT : max_idx;
        Score <= err_q ? '0 : max_val;
      end else if (state == HOLD && state_nxt == IDLE) begin
        Digit <= '0;
        Score <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    timed_out = 1'b0;
    Compute   = 1'b0;
    Busy      = 1'b1;
    Valid     = 1'b0;
    Err       = 1'b0;
    OutSel    = '0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    acc_idx   = scan_cnt - 4'd1;

    case (state)
      IDLE: begin
        Busy    = 1'b0;
        acc_clr = 1'b1;
        if (Start) state_nxt = REQ;
      end
      REQ: begin
        Compute = 1'b1;
        if (R) begin
          state_nxt = SCAN;
        end else if (to_cnt == TO_LIM) begin
          state_nxt = RELEASE;
          timed_out = 1'b1;
        end
      end
      SCAN: begin
        // Compute stays high so the sequencer keeps its outputs. Reads are
        // issued on counts 0..N_OUT-1; the value returns one cycle later, so
        // the compare for index k happens on count k+1. R is not watched here.
        Compute = 1'b1;
        if (scan_cnt < SCAN_LAST) OutSel = scan_cnt;
        acc_en = (scan_cnt != 4'd0);
        if (scan_cnt == SCAN_LAST) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!R) state_nxt = HOLD;
      end
      HOLD: begin
        Valid = 1'b1;
        Err   = err_q;
        if (Ack) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  argmax_acc #(
    .DATA_W(DATA_W)
  ) u_argmax (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (acc_clr),
    .En     (acc_en),
    .Idx    (acc_idx),
    .Val    (OutVal),
    .MaxIdx (max_idx),
    .MaxVal (max_val)
  );
endmodule

// File: tb/tb_classify_ctrl.sv
module tb_classify_ctrl;
  localparam int DW = 16;
  localparam int TO = 2047;

  logic          Clk = 1'b0;
  logic          Reset, Start, Ack, R;
  logic [DW-1:0] OutVal;
  logic          Compute, Busy, Valid, Err;
  logic [3:0]    OutSel, Digit;
  logic [DW-1:0] Score;

  classify_ctrl #(.DATA_W(DW), .N_OUT(10), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .R(R), .OutVal(OutVal),
    .Compute(Compute), .OutSel(OutSel), .Busy(Busy), .Valid(Valid),
    .Digit(Digit), .Score(Score), .Err(Err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Sequencer model: output memory with one-cycle read latency, and a
  // registered done flag that rises r_delay cycles into Compute and drops
  // one cycle after Compute falls.
  logic signed [DW-1:0] vec [16];
  int   r_delay;
  logic r_block;
  int   ccnt;
  always @(posedge Clk) begin
    OutVal <= vec[OutSel];
    if (Reset || !Compute) begin
      R    <= 1'b0;
      ccnt <= 0;
    end else begin
      ccnt <= ccnt + 1;
      if (!r_block && (ccnt + 1 >= r_delay)) R <= 1'b1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic [3:0]    exp_d;
  logic [DW-1:0] exp_s;
  logic          exp_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int v[10]);
    for (int i = 0; i < 16; i++) vec[i] = '0;
    for (int i = 0; i < 10; i++) vec[i] = 16'(v[i]);
  endtask

  // Reference: first index holding the largest signed value.
  function automatic void ref_argmax(output logic [3:0] d, output logic [DW-1:0] s);
    int best;
    best = 0;
    for (int i = 1; i < 10; i++) if (vec[i] > vec[best]) best = i;
    d = best[3:0];
    s = vec[best];
  endfunction

  task automatic run_once(input int delay, input logic blk, input logic poke_req);
    int t0, c_r, c_cf, n;
    r_delay = delay;
    r_block = blk;
    if (blk) begin
      exp_d = 4'hF; exp_s = '0; exp_e = 1'b1;
    end else begin
      ref_argmax(exp_d, exp_s); exp_e = 1'b0;
    end
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0; t0 = cyc;
    chk("compute_after_start", Compute, 1);
    chk("busy_after_start", Busy, 1);
    if (poke_req) begin
      @(negedge Clk); Start = 1'b1;
      @(negedge Clk); Start = 1'b0;
    end
    c_r = -1; c_cf = -1; n = 0;
    while (Valid !== 1'b1 && n < 3000) begin
      if (R === 1'b1 && c_r < 0) c_r = cyc;
      if (c_r >= 0 && Compute === 1'b0 && c_cf < 0) c_cf = cyc;
      @(negedge Clk); n++;
    end
    chk("valid_within_bound", Valid, 1);
    chk("compute_low_in_hold", Compute, 0);
    chk("r_low_at_valid", R, 0);
    chk("err_flag", Err, exp_e);
    chk("digit", Digit, exp_d);
    chk("score", Score, exp_s);
    if (blk) chk("timeout_latency", cyc - t0, TO + 2);
    else     chk("scan_to_release", c_cf - c_r, 12);
  endtask

  task automatic hold_and_ack(input int wait_cyc, input logic poke, input logic start_with_ack);
    for (int i = 0; i < wait_cyc; i++) begin
      Start = (poke && i == 10);
      @(negedge Clk);
      chk("hold_valid", Valid, 1);
      chk("hold_digit", Digit, exp_d);
      chk("hold_score", Score, exp_s);
      chk("hold_err", Err, exp_e);
    end
    Start = start_with_ack;
    Ack   = 1'b1;
    @(negedge Clk);
    Ack = 1'b0; Start = 1'b0;
    chk("ack_valid_low", Valid, 0);
    chk("ack_busy_low", Busy, 0);
    chk("ack_compute_low", Compute, 0);
    chk("idle_digit_zero", Digit, 0);
    chk("idle_score_zero", Score, 0);
    chk("idle_err_zero", Err, 0);
    chk("idle_outsel_zero", OutSel, 0);
    @(negedge Clk);
    chk("no_new_run", Busy, 0);
  endtask

  initial begin
    int n;
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0; r_block = 1'b0; r_delay = 4;
    for (int i = 0; i < 16; i++) vec[i] = '0;
    repeat (3) @(negedge Clk);
    chk("rst_compute", Compute, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_valid", Valid, 0);
    chk("rst_outsel", OutSel, 0);
    chk("rst_digit", Digit, 0);
    chk("rst_score", Score, 0);
    chk("rst_err", Err, 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Normal run with a tie at the max; Start poked during REQ and HOLD,
    // then Start together with Ack in HOLD.
    load('{5, -3, 12, 7, 12, 0, 1, -8, 2, 9});
    run_once(830, 1'b0, 1'b1);
    hold_and_ack(50, 1'b1, 1'b1);

    // All negative values.
    load('{-9, -2, -5, -6, -3, -4, -8, -10, -11, -7});
    run_once(20, 1'b0, 1'b0);
    hold_and_ack(3, 1'b0, 1'b0);

    // Sequencer never answers.
    run_once(0, 1'b1, 1'b0);
    hold_and_ack(2, 1'b0, 1'b0);
    r_block = 1'b0;

    // Reset in the middle of the scan.
    load('{100, 200, 300, 400, 500, 600, 700, 800, 900, 1000});
    r_delay = 5;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    n = 0;
    while (OutSel !== 4'd5 && n < 200) begin
      @(negedge Clk); n++;
    end
    chk("reached_sel5", OutSel, 5);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midrst_compute", Compute, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_outsel", OutSel, 0);
    chk("midrst_valid", Valid, 0);
    Reset = 1'b0;
    @(negedge Clk);
    load('{-50, -40, -30, -20, -45, -35, -25, -21, -60, -70});
    run_once(7, 1'b0, 1'b0);
    hold_and_ack(1, 1'b0, 1'b0);

    // Back-to-back: large max first, then a vector that must not inherit it.
    load('{10, 20, 30, 40, 50, 60, 70, 30000, 90, 100});
    run_once(12, 1'b0, 1'b0);
    hold_and_ack(0, 1'b0, 1'b0);
    load('{-1000, -999, -1001, -5000, -999, -2, -3, -4, -2, -32768});
    run_once(9, 1'b0, 1'b0);
    hold_and_ack(0, 1'b0, 1'b0);

    // Randomized vectors; later ones use a narrow range to force ties.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 10; i++) begin
        if (k < 3) vec[i] = 16'($urandom);
        else       vec[i] = 16'(int'($urandom_range(0, 6)) - 3);
      end
      run_once(int'($urandom_range(1, 40)), 1'b0, 1'b0);
      hold_and_ack(int'($urandom_range(0, 5)), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
